// File: rtl/ahb_to_wb_pkg.sv
// Shared AHB/Wishbone encodings and bridge FSM states for the ahb_to_wb bridge.
// The sel-to-hsize mapping lives here so every user derives transfer size the same way.
package ahb_to_wb_pkg;

    localparam int NAHBSLV_DEFAULT = 16;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam logic [2:0] CTI_CLASSIC   = 3'b000;
    localparam logic [2:0] CTI_INCRBURST = 3'b010;
    localparam logic [2:0] CTI_ENDBURST  = 3'b111;
    localparam logic [1:0] BTE_LINEAR    = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Irregular lane patterns fall back to a full word access.
    function automatic logic [2:0] sel_to_hsize(input logic [3:0] sel);
        logic [2:0] size;
        case (sel)
            4'b1111:                            size = HSIZE_WORD;
            4'b0011, 4'b1100:                   size = HSIZE_HALF;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = HSIZE_BYTE;
            default:                            size = HSIZE_WORD;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/ahb_to_wb.sv
// Wishbone B3 slave to AHB master bridge: one Wishbone beat becomes one AHB transfer,
// with the AHB response returned as a single-cycle ack/err/rty pulse.
module ahb_to_wb
    import ahb_to_wb_pkg::*;
#(
    parameter int NAHBSLV = NAHBSLV_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    input  logic [3:0]         wb_sel_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [2:0]         wb_cti_i,
    input  logic [1:0]         wb_bte_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    output logic               wb_err_o,
    output logic               wb_rty_o,
    output logic [0:NAHBSLV-1] ahbsi_hsel,
    output logic [31:0]        ahbsi_haddr,
    output logic               ahbsi_hwrite,
    output logic [1:0]         ahbsi_htrans,
    output logic [2:0]         ahbsi_hsize,
    output logic [2:0]         ahbsi_hburst,
    output logic [31:0]        ahbsi_hwdata,
    input  logic               ahbso_hready,
    input  logic [1:0]         ahbso_hresp,
    input  logic [31:0]        ahbso_hrdata
);

    state_t      state_q, state_d;
    logic        burst_q, burst_d;
    logic        abort_q, abort_d;
    logic        resp_ok_q, resp_ok_d;
    logic [2:0]  cti_q, cti_d;
    logic [31:0] dat_q, dat_d;
    logic        hsel_q, hsel_d;

    logic [31:0] rdata_d;
    logic        ack_d, err_d, rty_d;
    logic [31:0] haddr_d;
    logic        hwrite_d;
    logic [1:0]  htrans_d;
    logic [2:0]  hsize_d;
    logic [2:0]  hburst_d;
    logic [31:0] hwdata_d;
    logic        burst_cont;

    // Burst type is ignored: every burst runs as a linear increment.
    logic unused_bte;
    assign unused_bte = ^wb_bte_i;

    assign ahbsi_hsel = {NAHBSLV{hsel_q}};

    always_comb begin
        state_d    = state_q;
        burst_d    = burst_q;
        abort_d    = abort_q;
        resp_ok_d  = resp_ok_q;
        cti_d      = cti_q;
        dat_d      = dat_q;
        hsel_d     = hsel_q;
        rdata_d    = wb_dat_o;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rty_d      = 1'b0;
        haddr_d    = ahbsi_haddr;
        hwrite_d   = ahbsi_hwrite;
        htrans_d   = ahbsi_htrans;
        hsize_d    = ahbsi_hsize;
        hburst_d   = ahbsi_hburst;
        hwdata_d   = ahbsi_hwdata;
        burst_cont = 1'b0;

        case (state_q)
            ST_IDLE: begin
                htrans_d = HTRANS_IDLE;
                hsel_d   = burst_q;
                if (wb_cyc_i && wb_stb_i) begin
                    state_d  = ST_ADDR;
                    cti_d    = wb_cti_i;
                    dat_d    = wb_dat_i;
                    abort_d  = 1'b0;
                    haddr_d  = wb_adr_i;
                    hwrite_d = wb_we_i;
                    hsel_d   = 1'b1;
                    htrans_d = burst_q ? HTRANS_SEQ : HTRANS_NONSEQ;
                    hburst_d = (wb_cti_i == CTI_CLASSIC) ? HBURST_SINGLE : HBURST_INCR;
                    hsize_d  = sel_to_hsize(wb_sel_i);
                end
            end
            ST_ADDR: begin
                if (!wb_cyc_i) abort_d = 1'b1;
                if (ahbso_hready) begin
                    state_d  = ST_DATA;
                    htrans_d = (cti_q == CTI_INCRBURST) ? HTRANS_BUSY : HTRANS_IDLE;
                    hwdata_d = dat_q;
                end
            end
            ST_DATA: begin
                // A master that gives up the cycle still lets the AHB transfer finish.
                if (!wb_cyc_i) abort_d = 1'b1;
                if (ahbso_hready) begin
                    state_d   = ST_RESP;
                    rdata_d   = ahbso_hrdata;
                    resp_ok_d = (ahbso_hresp == HRESP_OKAY);
                    if (!abort_d) begin
                        case (ahbso_hresp)
                            HRESP_OKAY:  ack_d = 1'b1;
                            HRESP_ERROR: err_d = 1'b1;
                            default:     rty_d = 1'b1;
                        endcase
                    end
                    burst_cont = (cti_q == CTI_INCRBURST) && (ahbso_hresp == HRESP_OKAY) && !abort_d;
                    htrans_d   = burst_cont ? HTRANS_BUSY : HTRANS_IDLE;
                    hsel_d     = burst_cont;
                end
            end
            ST_RESP: begin
                state_d  = ST_IDLE;
                burst_d  = (cti_q == CTI_INCRBURST) && resp_ok_q && !abort_q;
                htrans_d = HTRANS_IDLE;
                hsel_d   = burst_d;
            end
            default: begin
                state_d = ST_IDLE;
                burst_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            burst_q      <= 1'b0;
            abort_q      <= 1'b0;
            resp_ok_q    <= 1'b0;
            cti_q        <= CTI_CLASSIC;
            dat_q        <= '0;
            hsel_q       <= 1'b0;
            wb_dat_o     <= '0;
            wb_ack_o     <= 1'b0;
            wb_err_o     <= 1'b0;
            wb_rty_o     <= 1'b0;
            ahbsi_haddr  <= '0;
            ahbsi_hwrite <= 1'b0;
            ahbsi_htrans <= HTRANS_IDLE;
            ahbsi_hsize  <= HSIZE_WORD;
            ahbsi_hburst <= HBURST_SINGLE;
            ahbsi_hwdata <= '0;
        end else begin
            state_q      <= state_d;
            burst_q      <= burst_d;
            abort_q      <= abort_d;
            resp_ok_q    <= resp_ok_d;
            cti_q        <= cti_d;
            dat_q        <= dat_d;
            hsel_q       <= hsel_d;
            wb_dat_o     <= rdata_d;
            wb_ack_o     <= ack_d;
            wb_err_o     <= err_d;
            wb_rty_o     <= rty_d;
            ahbsi_haddr  <= haddr_d;
            ahbsi_hwrite <= hwrite_d;
            ahbsi_htrans <= htrans_d;
            ahbsi_hsize  <= hsize_d;
            ahbsi_hburst <= hburst_d;
            ahbsi_hwdata <= hwdata_d;
        end
    end

endmodule

// File: tb/tb_ahb_to_wb.sv
// Bench for ahb_to_wb: behavioural AHB memory slave, directed vector table,
// hand-written corner sequences and randomized beats against a reference memory.
module tb_ahb_to_wb;
    import ahb_to_wb_pkg::*;

    localparam int TERM_NONE = 0, TERM_ACK = 1, TERM_ERR = 2, TERM_RTY = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wb_adr = '0, wb_dat_w = '0, wb_dat_r;
    logic [3:0]  wb_sel = '0;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [2:0]  wb_cti = '0;
    logic [1:0]  wb_bte = '0;
    logic        wb_ack, wb_err, wb_rty;
    logic [0:15] hsel;
    logic [31:0] haddr, hwdata;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic        hready = 1'b1;
    logic [1:0]  hresp = '0;
    logic [31:0] hrdata = '0;

    ahb_to_wb #(.NAHBSLV(16)) dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w), .wb_sel_i(wb_sel),
        .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
        .wb_cti_i(wb_cti), .wb_bte_i(wb_bte),
        .wb_dat_o(wb_dat_r), .wb_ack_o(wb_ack), .wb_err_o(wb_err), .wb_rty_o(wb_rty),
        .ahbsi_hsel(hsel), .ahbsi_haddr(haddr), .ahbsi_hwrite(hwrite),
        .ahbsi_htrans(htrans), .ahbsi_hsize(hsize), .ahbsi_hburst(hburst),
        .ahbsi_hwdata(hwdata),
        .ahbso_hready(hready), .ahbso_hresp(hresp), .ahbso_hrdata(hrdata)
    );

    // Clock/reset block.
    always #5 clk = ~clk;
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] lanes);
        logic [31:0] v;
        v = old;
        for (int b = 0; b < 4; b++) if (lanes[b]) v[8*b +: 8] = d[8*b +: 8];
        return v;
    endfunction

    // Behavioural AHB memory slave with programmable wait states and response.
    logic [31:0] slv_mem [0:63];
    logic [31:0] ref_mem [0:63];
    int          aw_left = 0, dw_left = 0, slv_done = 0;
    logic [1:0]  resp_plan = HRESP_OKAY;

    initial begin
        logic        pend, pwrite, prev_ready, prev_aphase, aphase, prev_hwrite;
        logic [31:0] paddr, prev_haddr;
        logic [2:0]  psize, prev_hsize;
        logic [3:0]  lanes;
        for (int i = 0; i < 64; i++) slv_mem[i] = '0;
        pend = 0; pwrite = 0; prev_ready = 1; prev_aphase = 0; prev_hwrite = 0;
        paddr = '0; prev_haddr = '0; psize = '0; prev_hsize = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                pend = 0; prev_ready = 1; prev_aphase = 0;
                aw_left = 0; dw_left = 0;
                hready = 1; hresp = HRESP_OKAY;
                continue;
            end
            if (pend && prev_ready) begin
                if (pwrite) begin
                    case (psize)
                        HSIZE_BYTE: lanes = 4'b0001 << paddr[1:0];
                        HSIZE_HALF: lanes = paddr[1] ? 4'b1100 : 4'b0011;
                        default:    lanes = 4'b1111;
                    endcase
                    slv_mem[paddr[7:2]] = merge(slv_mem[paddr[7:2]], hwdata, lanes);
                end
                slv_done++;
                pend = 0;
            end
            if (prev_aphase && prev_ready) begin
                pend = 1; paddr = prev_haddr; pwrite = prev_hwrite; psize = prev_hsize;
            end
            aphase = hsel[0] && htrans[1];
            if (pend) begin
                hready = (dw_left == 0);
                if (!hready) dw_left--;
                hresp  = hready ? resp_plan : HRESP_OKAY;
                hrdata = slv_mem[paddr[7:2]];
            end else if (aphase) begin
                hready = (aw_left == 0);
                if (!hready) aw_left--;
                hresp  = HRESP_OKAY;
            end else begin
                hready = 1;
                hresp  = HRESP_OKAY;
            end
            prev_ready = hready; prev_aphase = aphase;
            prev_haddr = haddr; prev_hwrite = hwrite; prev_hsize = hsize;
        end
    end

    // Driver: one Wishbone beat, observed from strobe sample to termination.
    typedef struct {
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic [2:0]  size;
        logic        hwrite;
        logic [15:0] hsel;
        logic [31:0] haddr;
        logic        addr_stable;
        logic [1:0]  dtrans;
        logic [31:0] hwdata;
        int          term;
        logic [31:0] rdata;
        int          lat;
        logic        extra_pulse;
        logic [1:0]  idle_trans;
    } res_t;

    task automatic do_beat(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [2:0] cti, input int aw,
                           input int dw, input logic [1:0] resp, input logic drop,
                           output res_t r);
        logic [1:0]  prev_trans;
        logic [31:0] prev_wdata;
        int          budget;
        r = '{default: 0};
        prev_trans = '0; prev_wdata = '0;
        @(negedge clk);
        aw_left = aw; dw_left = dw; resp_plan = resp;
        wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_dat_w = dat;
        wb_sel = sel; wb_cti = cti;
        @(posedge clk);
        budget = drop ? 10 : 30;
        r.addr_stable = 1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (k == 1) begin
                r.trans = htrans; r.burst = hburst; r.size = hsize; r.hwrite = hwrite;
                r.hsel = hsel; r.haddr = haddr;
                if (drop) begin wb_cyc = 0; wb_stb = 0; end
            end else if (htrans[1] && haddr !== r.haddr) begin
                r.addr_stable = 0;
            end
            if (wb_ack || wb_err || wb_rty) begin
                r.term = wb_ack ? TERM_ACK : (wb_err ? TERM_ERR : TERM_RTY);
                r.rdata = wb_dat_r; r.lat = k; r.dtrans = prev_trans; r.hwdata = prev_wdata;
                break;
            end
            prev_trans = htrans; prev_wdata = hwdata;
        end
        if (r.term != TERM_NONE) begin
            @(posedge clk);
            #1;
            wb_stb = 0;
            if (cti != CTI_INCRBURST) wb_cyc = 0;
            @(negedge clk);
            r.extra_pulse = wb_ack | wb_err | wb_rty;
            r.idle_trans = htrans;
        end else begin
            wb_stb = 0; wb_cyc = 0;
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [2:0]  cti;
        int          aw;
        int          dw;
        logic [1:0]  resp;
        logic [1:0]  e_trans;
        logic [2:0]  e_burst;
        logic [2:0]  e_size;
        logic [1:0]  e_dtrans;
        int          e_term;
        logic [31:0] e_rdata;
        int          e_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [2:0] cti, input int aw,
                           input int dw, input logic [1:0] resp, input logic [1:0] e_trans,
                           input logic [2:0] e_burst, input logic [2:0] e_size,
                           input logic [1:0] e_dtrans, input int e_term,
                           input logic [31:0] e_rdata, input int e_lat);
        vec_t v;
        v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.cti = cti; v.aw = aw; v.dw = dw;
        v.resp = resp; v.e_trans = e_trans; v.e_burst = e_burst; v.e_size = e_size;
        v.e_dtrans = e_dtrans; v.e_term = e_term; v.e_rdata = e_rdata; v.e_lat = e_lat;
        vecs.push_back(v);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_hsel"},   32'(hsel),   32'h0);
        check({tag, "_haddr"},  haddr,       32'h0);
        check({tag, "_hwrite"}, 32'(hwrite), 32'h0);
        check({tag, "_htrans"}, 32'(htrans), 32'(HTRANS_IDLE));
        check({tag, "_hsize"},  32'(hsize),  32'(HSIZE_WORD));
        check({tag, "_hburst"}, 32'(hburst), 32'h0);
        check({tag, "_hwdata"}, hwdata,      32'h0);
        check({tag, "_dat_o"},  wb_dat_r,    32'h0);
        check({tag, "_pulses"}, {29'b0, wb_ack, wb_err, wb_rty}, 32'h0);
    endtask

    // Scoreboard for randomized reads.
    logic [31:0] exp_q[$];

    initial begin
        res_t        r;
        logic [31:0] a;
        logic [2:0]  e_size;
        logic [3:0]  sel;
        int          k, idx, off, aw, dw, done_before;
        logic        we;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 0;

        // Directed table: classic, burst, narrow, wait-state and non-OKAY beats.
        add_vec(1, 32'h2000_0000, 32'd0, 4'hF, CTI_CLASSIC, 0, 0, HRESP_OKAY, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD, HTRANS_IDLE, TERM_ACK, 0, 3);
        add_vec(1, 32'h2000_0004, 32'd1, 4'hF, CTI_CLASSIC, 0, 0, HRESP_OKAY, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD, HTRANS_IDLE, TERM_ACK, 0, 3);
        add_vec(1, 32'h2000_0008, 32'd2, 4'hF, CTI_CLASSIC, 0, 0, HRESP_OKAY, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD, HTRANS_IDLE, TERM_ACK, 0, 3);
        add_vec(0, 32'h2000_0000, 32'd0, 4'hF, CTI_CLASSIC, 0, 0, HRESP_OKAY, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD, HTRANS_IDLE, TERM_ACK, 32'd0, 3);
        add_vec(0, 32'h2000_0008, 32'd0, 4'hF, CTI_CLASSIC, 0, 0, HRESP_OKAY, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD, HTRANS_IDLE, TERM_ACK, 32'd2, 3);
        for (int i = 0; i < 5; i++)
            add_vec(1, 32'h2000_0000 + 32'(4*i), 32'(i), 4'hF, (i == 4) ? CTI_ENDBURST : CTI_INCRBURST, 0, 0, HRESP_OKAY,
                    (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, HBURST_INCR, HSIZE_WORD,
                    (i == 4) ? HTRANS_IDLE : HTRANS_BUSY, TERM_ACK, 0, 3);
        for (int i = 0; i < 5; i++)
            add_vec(0, 32'h2000_0000 + 32'(4*i), 32'd0, 4'hF, (i == 4) ? CTI_ENDBURST : CTI_INCRBURST, 0, 0, HRESP_OKAY,
                    (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, HBURST_INCR, HSIZE_WORD,
                    (i == 4) ? HTRANS_IDLE : HTRANS_BUSY, TERM_ACK, 32'(i), 3);
        add_vec(1, 32'h2000_0005, 32'h0000_AB00, 4'b0010, CTI_CLASSIC, 0, 0, HRESP_OKAY, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_BYTE, HTRANS_IDLE, TERM_ACK, 0, 3);
        add_vec(1, 32'h2000_000A, 32'h1234_0000, 4'b1100, CTI_CLASSIC, 0, 0, HRESP_OKAY, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_HALF, HTRANS_IDLE, TERM_ACK, 0, 3);
        add_vec(0, 32'h2000_0004, 32'd0, 4'b0101, CTI_CLASSIC, 0, 0, HRESP_OKAY, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD, HTRANS_IDLE, TERM_ACK, 32'h0000_AB01, 3);
        add_vec(0, 32'h2000_0000, 32'd0, 4'hF, CTI_CLASSIC, 1, 2, HRESP_ERROR, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD, HTRANS_IDLE, TERM_ERR, 0, 6);
        add_vec(0, 32'h2000_0004, 32'd0, 4'hF, CTI_CLASSIC, 0, 0, HRESP_RETRY, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD, HTRANS_IDLE, TERM_RTY, 0, 3);
        add_vec(0, 32'h2000_0008, 32'd0, 4'hF, CTI_CLASSIC, 2, 0, HRESP_SPLIT, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD, HTRANS_IDLE, TERM_RTY, 0, 5);
        add_vec(0, 32'h2000_0000, 32'd0, 4'hF, CTI_INCRBURST, 0, 0, HRESP_OKAY, HTRANS_NONSEQ, HBURST_INCR, HSIZE_WORD, HTRANS_BUSY, TERM_ACK, 32'd0, 3);
        add_vec(0, 32'h2000_0004, 32'd0, 4'hF, CTI_INCRBURST, 0, 0, HRESP_ERROR, HTRANS_SEQ, HBURST_INCR, HSIZE_WORD, HTRANS_BUSY, TERM_ERR, 0, 3);
        add_vec(0, 32'h2000_0008, 32'd0, 4'hF, CTI_ENDBURST, 0, 0, HRESP_OKAY, HTRANS_NONSEQ, HBURST_INCR, HSIZE_WORD, HTRANS_IDLE, TERM_ACK, 32'h1234_0002, 3);

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            do_beat(v.we, v.adr, v.dat, v.sel, v.cti, v.aw, v.dw, v.resp, 1'b0, r);
            check($sformatf("v%0d_htrans", i), 32'(r.trans), 32'(v.e_trans));
            check($sformatf("v%0d_hburst", i), 32'(r.burst), 32'(v.e_burst));
            check($sformatf("v%0d_hsize", i),  32'(r.size),  32'(v.e_size));
            check($sformatf("v%0d_hwrite", i), 32'(r.hwrite), 32'(v.we));
            check($sformatf("v%0d_hsel", i),   32'(r.hsel),  32'h0000_FFFF);
            check($sformatf("v%0d_haddr", i),  r.haddr, v.adr);
            check($sformatf("v%0d_addr_hold", i), 32'(r.addr_stable), 32'd1);
            check($sformatf("v%0d_data_htrans", i), 32'(r.dtrans), 32'(v.e_dtrans));
            check($sformatf("v%0d_term", i), 32'(r.term), 32'(v.e_term));
            check($sformatf("v%0d_latency", i), 32'(r.lat), 32'(v.e_lat));
            check($sformatf("v%0d_one_pulse", i), 32'(r.extra_pulse), 32'd0);
            check($sformatf("v%0d_after_htrans", i), 32'(r.idle_trans), 32'(HTRANS_IDLE));
            if (v.we) check($sformatf("v%0d_hwdata", i), r.hwdata, v.dat);
            if (!v.we && v.e_term == TERM_ACK) check($sformatf("v%0d_rdata", i), r.rdata, v.e_rdata);
            if (v.we && v.e_term == TERM_ACK)
                ref_mem[v.adr[7:2]] = merge(ref_mem[v.adr[7:2]], v.dat, v.sel);
        end

        // Cycle dropped during the address phase: AHB side completes, no pulse.
        done_before = slv_done;
        do_beat(0, 32'h2000_0000, 32'd0, 4'hF, CTI_CLASSIC, 0, 2, HRESP_OKAY, 1'b1, r);
        check("drop_no_pulse", 32'(r.term), 32'(TERM_NONE));
        check("drop_ahb_done", 32'(slv_done - done_before), 32'd1);
        check("drop_idle_hsel", 32'(hsel), 32'h0);

        // Reset during the data phase of an open burst.
        do_beat(0, 32'h2000_0008, 32'd0, 4'hF, CTI_INCRBURST, 0, 0, HRESP_OKAY, 1'b0, r);
        check("rstseq_open_rdata", r.rdata, 32'h1234_0002);
        @(negedge clk);
        aw_left = 0; dw_left = 4; resp_plan = HRESP_OKAY;
        wb_stb = 1; wb_we = 0; wb_adr = 32'h2000_000C; wb_sel = 4'hF; wb_cti = CTI_INCRBURST;
        @(posedge clk);
        @(negedge clk);
        check("rstseq_seq_beat", 32'(htrans), 32'(HTRANS_SEQ));
        @(negedge clk);
        rst = 1;
        #1;
        check_reset_values("midrst");
        wb_stb = 0; wb_cyc = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        do_beat(1, 32'h2000_0010, 32'hCAFE_F00D, 4'hF, CTI_CLASSIC, 0, 0, HRESP_OKAY, 1'b0, r);
        check("postrst_htrans", 32'(r.trans), 32'(HTRANS_NONSEQ));
        check("postrst_term", 32'(r.term), 32'(TERM_ACK));
        ref_mem[4] = 32'hCAFE_F00D;

        // Randomized classic beats against the reference memory.
        for (int n = 0; n < 40; n++) begin
            we  = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 15);
            k   = $urandom_range(0, 6);
            aw  = $urandom_range(0, 2);
            dw  = $urandom_range(0, 2);
            if (k == 0)      begin sel = 4'hF;  off = 0;     e_size = HSIZE_WORD; end
            else if (k <= 4) begin sel = 4'(1 << (k - 1)); off = k - 1; e_size = HSIZE_BYTE; end
            else if (k == 5) begin sel = 4'h3;  off = 0;     e_size = HSIZE_HALF; end
            else             begin sel = 4'hC;  off = 2;     e_size = HSIZE_HALF; end
            a = 32'h2000_0000 + 32'(idx * 4 + off);
            if (!we) exp_q.push_back(ref_mem[idx]);
            do_beat(we, a, $urandom, sel, CTI_CLASSIC, aw, dw, HRESP_OKAY, 1'b0, r);
            check($sformatf("rnd%0d_term", n), 32'(r.term), 32'(TERM_ACK));
            check($sformatf("rnd%0d_latency", n), 32'(r.lat), 32'(3 + aw + dw));
            check($sformatf("rnd%0d_hsize", n), 32'(r.size), 32'(e_size));
            if (we) begin
                if (r.term == TERM_ACK) ref_mem[idx] = merge(ref_mem[idx], wb_dat_w, sel);
            end else if (exp_q.size() > 0) begin
                check($sformatf("rnd%0d_rdata", n), r.rdata, exp_q.pop_front());
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
